muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EXE stage; supersedes the separate multiply/divider pair.

---
 rtl/muldiv_unit_pkg.sv | 11 +
 rtl/muldiv_div_step.sv | 17 +
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings, FSM states and op-decode helpers shared by the multiply/divide unit.
package muldiv_unit_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_e;
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division step; shifts in a dividend bit and subtracts the divisor if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] cur, sub;
  assign cur = {rem, in_bit};
  assign q_bit = cur >= {1'b0, divisor};
  assign sub = cur - {1'b0, divisor};
  // rem < divisor on entry, so the kept value always fits in WIDTH bits
  assign rem_nx = WIDTH'(q_bit ? sub : cur);
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU on operand magnitudes, sign-corrected in a final FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  md_state_e state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod_f;
  logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d, m1, m2, rem_nx, rem_f, quo_f;
  logic [WIDTH+MUL_STEP-1:0] mul_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic dz_q, dz_d, done_q, done_d, dbz_q, dbz_d;
  logic s1, s2, q_bit, dz_in;
  assign s1 = md_is_signed(op) & src1[WIDTH-1];
  assign s2 = md_is_signed(op) & src2[WIDTH-1];
  assign m1 = s1 ? -src1 : src1;
  assign m2 = s2 ? -src2 : src2;
  assign dz_in = md_is_div(op) && src2 == '0;
  // p_q holds {accumulator, multiplier} for mult and {remainder, dividend/quotient} for div
  assign mul_sum = {{MUL_STEP{1'b0}}, p_q[2*WIDTH-1:WIDTH]}
                 + {{MUL_STEP{1'b0}}, a_q} * {{WIDTH{1'b0}}, p_q[MUL_STEP-1:0]};
  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem    (p_q[2*WIDTH-1:WIDTH]),
    .in_bit (p_q[WIDTH-1]),
    .divisor(a_q),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );
  assign prod_f = neg_lo_q ? -p_q : p_q;
  assign rem_f = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  assign quo_f = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    a_d = a_q;
    cnt_d = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dbz_d = dbz_q;
    done_d = 1'b0;
    if (cancel) state_d = ST_IDLE;
    else case (state_q)
      ST_IDLE: if (start && !done_q) begin
        is_div_d = md_is_div(op);
        a_d = is_div_d ? m2 : m1;
        // divide by zero skips RUN; zero sign flags let FIX pass src1/all-ones straight through
        p_d = dz_in ? {src1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, is_div_d ? m1 : m2};
        neg_lo_d = ~dz_in & (s1 ^ s2);
        neg_hi_d = ~dz_in & s1;
        dz_d = dz_in;
        dbz_d = 1'b0;
        cnt_d = '0;
        state_d = dz_in ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        p_d = is_div_q ? {rem_nx, p_q[WIDTH-2:0], q_bit} : {mul_sum, p_q[WIDTH-1:MUL_STEP]};
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == (is_div_q ? DIV_LAST : MUL_LAST) ? ST_FIX : ST_RUN;
      end
      ST_FIX: begin
        hi_d = is_div_q ? rem_f : prod_f[2*WIDTH-1:WIDTH];
        lo_d = is_div_q ? quo_f : prod_f[WIDTH-1:0];
        dbz_d = dz_q;
        done_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      p_q <= '0;
      a_q <= '0;
      cnt_q <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      dbz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dbz_q <= dbz_d;
      done_q <= done_d;
    end
  end
  // the done cycle still counts as busy so a new start lands the cycle after
  assign busy = state_q != ST_IDLE || done_q;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for a 32-bit/step-1 and a 16-bit/step-4 muldiv_unit.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] start_v = '0, cancel_v = '0;
  logic [1:0] op_v [2];
  logic [31:0] a_v [2], b_v [2];
  logic [1:0] busy_v, done_v, dbz_v;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1;
  logic [64:0] q0 [$], q1 [$];
  logic [64:0] e0, e1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .op(op_v[0]), .src1(a_v[0]), .src2(b_v[0]),
    .cancel(cancel_v[0]), .busy(busy_v[0]), .done(done_v[0]), .hi(hi0), .lo(lo0), .div_by_zero(dbz_v[0])
  );
  muldiv_unit #(.WIDTH(16), .MUL_STEP(4)) dut1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .op(op_v[1]), .src1(a_v[1][15:0]), .src2(b_v[1][15:0]),
    .cancel(cancel_v[1]), .busy(busy_v[1]), .done(done_v[1]), .hi(hi1), .lo(lo1), .div_by_zero(dbz_v[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint m, sa, sb, p, q, r;
    logic sg;
    m = (longint'(1) << w) - 1;
    sg = !op[1] ? !op[0] : !op[0];
    sa = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (op[1] && b == 0) return {1'b1, a, 32'(m)};
    if (!op[1]) begin
      p = sa * sb;
      return {1'b0, 32'((p >> w) & m), 32'(p & m)};
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 32'(r & m), 32'(q & m)};
  endfunction

  function automatic int lat(input int d, input logic [1:0] op, input logic [31:0] b);
    int w = d ? 16 : 32;
    int ms = d ? 4 : 1;
    return (op[1] && b == 0) ? 1 : op[1] ? w + 1 : w / ms + 1;
  endfunction

  task automatic launch(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    start_v[d] = 1'b1;
    cancel_v[d] = c;
    op_v[d] = op;
    a_v[d] = a;
    b_v[d] = b;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    cancel_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int exp_lat, input int n0);
    int n = n0;
    while (!done_v[d] && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("latency%0d", d), 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1;
    check($sformatf("idle_after%0d", d), 64'(busy_v[d]), 64'(0));
  endtask

  task automatic do_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [64:0] e);
    launch(d, op, a, b, 1'b0);
    if (d != 0) q1.push_back(e);
    else q0.push_back(e);
    check($sformatf("busy_start%0d", d), 64'(busy_v[d]), 64'(1));
    check($sformatf("dbz_clr%0d", d), 64'(dbz_v[d]), 64'(0));
    wait_done(d, lat(d, op, b), 0);
  endtask

  task automatic do_ref(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    do_op(d, op, a, b, model(d ? 16 : 32, op, a, b));
  endtask

  always @(negedge clk) if (done_v[0]) begin
    if (q0.size() == 0) check("spurious_done0", 64'(1), 64'(0));
    else begin
      e0 = q0.pop_front();
      check("hi0", 64'(hi0), 64'(e0[63:32]));
      check("lo0", 64'(lo0), 64'(e0[31:0]));
      check("dbz0", 64'(dbz_v[0]), 64'(e0[64]));
    end
  end

  always @(negedge clk) if (done_v[1]) begin
    if (q1.size() == 0) check("spurious_done1", 64'(1), 64'(0));
    else begin
      e1 = q1.pop_front();
      check("hi1", 64'(hi1), 64'(e1[63:32]));
      check("lo1", 64'(lo1), 64'(e1[31:0]));
      check("dbz1", 64'(dbz_v[1]), 64'(e1[64]));
    end
  end

  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    for (int d = 0; d < 2; d++) begin
      op_v[d] = '0;
      a_v[d] = '0;
      b_v[d] = '0;
    end
    #3;
    check("rst_busy", 64'(busy_v), 64'(0));
    check("rst_done", 64'(done_v), 64'(0));
    check("rst_hilo0", {hi0, lo0}, 64'(0));
    check("rst_dbz", 64'(dbz_v), 64'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    // directed results with hand-derived expectations
    do_op(0, 2'b00, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'd2, {1'b0, 32'h0000_0001, 32'hFFFF_FFFE});
    do_op(0, 2'b11, 32'd100, 32'd7, {1'b0, 32'h0000_0002, 32'h0000_000E});
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000});
    do_op(0, 2'b10, 32'd1234, 32'd0, {1'b1, 32'h0000_04D2, 32'hFFFF_FFFF});
    check("dbz_held", 64'(dbz_v[0]), 64'(1));
    do_op(0, 2'b11, 32'd9, 32'd3, {1'b0, 32'h0, 32'h3});
    // cancel mid-op: no done, results untouched
    launch(0, 2'b11, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk) cancel_v[0] = 1'b1;
    @(posedge clk);
    #1 cancel_v[0] = 1'b0;
    check("cancel_busy", 64'(busy_v[0]), 64'(0));
    repeat (40) @(posedge clk);
    check("cancel_hilo", {hi0, lo0}, {32'h0, 32'h3});
    launch(0, 2'b01, 32'd5, 32'd6, 1'b1);
    check("startcancel_busy", 64'(busy_v[0]), 64'(0));
    repeat (40) @(posedge clk);
    check("startcancel_hilo", {hi0, lo0}, {32'h0, 32'h3});
    // start pulses while busy are ignored
    launch(0, 2'b11, 32'd1000, 32'd10, 1'b0);
    q0.push_back({1'b0, 32'h0, 32'd100});
    launch(0, 2'b00, 32'd3, 32'd4, 1'b0);
    launch(0, 2'b10, 32'hFFFF_0000, 32'd0, 1'b0);
    launch(0, 2'b01, 32'd77, 32'd88, 1'b0);
    wait_done(0, 33, 3);
    // asynchronous reset mid-op
    launch(0, 2'b00, 32'd123, 32'd456, 1'b0);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_v[0]), 64'(0));
    check("midrst_done", 64'(done_v[0]), 64'(0));
    check("midrst_hilo", {hi0, lo0}, 64'(0));
    check("midrst_dbz", 64'(dbz_v[0]), 64'(0));
    @(negedge clk) resetn = 1'b1;
    // narrow, 4-bit-per-cycle instance
    do_op(1, 2'b00, 32'h7FFF, 32'h8000, {1'b0, 32'h0000_C000, 32'h0000_8000});
    do_op(1, 2'b10, 32'h8000, 32'hFFFF, {1'b0, 32'h0, 32'h0000_8000});
    do_op(1, 2'b10, 32'h0042, 32'h0, {1'b1, 32'h0000_0042, 32'h0000_FFFF});
    // random regression against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 7 == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_ref(0, op, a, b);
      do_ref(1, op, a & 32'hFFFF, b & 32'hFFFF);
    end
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
